// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter controller: Start/Done handshake, branch-target
// LUT pointer, halt/sentinel detection and a saturating RUN-cycle counter.
module pc_sequencer #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic             BranchTaken,
    input  logic [2:0]       BranchAddr,
    input  logic             HaltInstr,
    output logic [2:0]       LutAddr,
    input  logic [PC_W-1:0]  LutTarget,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_running;
    logic             r_done;
    logic             w_taken;
    logic             w_sentinel;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign LutAddr    = BranchAddr;
    assign w_taken    = BranchEn & BranchTaken;
    assign w_sentinel = (LutTarget == {PC_W{1'b1}});

    always_comb begin
        w_next     = r_state;
        w_pc_next  = r_pc;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (Start) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (!Start) w_next = S_RUN;
            end
            S_RUN: begin
                // Restart is checked before Stall so a stalled core can still be restarted.
                if (Start) begin
                    w_next = S_LOAD;
                end else if (!Stall) begin
                    w_cnt_next = sat_inc(r_cnt);
                    if (HaltInstr) begin
                        w_next = S_HALT;
                    end else if (w_taken && w_sentinel) begin
                        w_next = S_HALT;
                    end else if (w_taken) begin
                        w_pc_next = LutTarget;
                    end else begin
                        w_pc_next = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            S_HALT: begin
                if (Start) w_next = S_LOAD;
            end
            default: w_next = S_IDLE;
        endcase
        // Clearing on entry as well as during LOAD makes Done/CycleCount read zero in the first LOAD cycle.
        if (w_next == S_LOAD || r_state == S_LOAD) begin
            w_pc_next  = '0;
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_cnt     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pc      <= w_pc_next;
            r_cnt     <= w_cnt_next;
            r_running <= (w_next == S_RUN);
            r_done    <= (w_next == S_HALT);
        end
    end

    assign PC         = r_pc;
    assign Running    = r_running;
    assign Done       = r_done;
    assign CycleCount = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by randomized traffic,
// all checked against a mode/arithmetic reference model.
module tb_pc_sequencer;
    localparam int PC_W  = 10;
    localparam int CNT_W = 16;
    localparam int PC_MAX  = (1 << PC_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_HALT = 3;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Start = 1'b0;
    logic             Stall = 1'b0;
    logic             BranchEn = 1'b0;
    logic             BranchTaken = 1'b0;
    logic [2:0]       BranchAddr = 3'd0;
    logic             HaltInstr = 1'b0;
    logic [2:0]       LutAddr;
    logic [PC_W-1:0]  LutTarget = '0;
    logic [PC_W-1:0]  PC;
    logic             Running;
    logic             Done;
    logic [CNT_W-1:0] CycleCount;

    int n_asserts = 0;
    int n_fail    = 0;

    int m_mode = M_IDLE;
    int m_pc   = 0;
    int m_cnt  = 0;

    pc_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchEn(BranchEn), .BranchTaken(BranchTaken), .BranchAddr(BranchAddr),
        .HaltInstr(HaltInstr), .LutAddr(LutAddr), .LutTarget(LutTarget),
        .PC(PC), .Running(Running), .Done(Done), .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: what the next edge does to the program counter, counter and mode.
    task automatic model_next();
        if (Reset) begin
            m_mode = M_IDLE; m_pc = 0; m_cnt = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (Start) m_mode = M_LOAD;
                M_LOAD: begin
                    m_pc = 0; m_cnt = 0;
                    if (!Start) m_mode = M_RUN;
                end
                M_RUN: begin
                    if (Start) begin
                        m_mode = M_LOAD; m_pc = 0; m_cnt = 0;
                    end else if (!Stall) begin
                        m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
                        if (HaltInstr) m_mode = M_HALT;
                        else if (BranchEn && BranchTaken) begin
                            if (int'(LutTarget) == PC_MAX) m_mode = M_HALT;
                            else m_pc = int'(LutTarget);
                        end else m_pc = (m_pc + 1) % (PC_MAX + 1);
                    end
                end
                default: if (Start) begin
                    m_mode = M_LOAD; m_pc = 0; m_cnt = 0;
                end
            endcase
        end
    endtask

    task automatic step(input bit do_chk);
        #1;
        if (do_chk) chk("lut_addr", 32'(LutAddr), 32'(BranchAddr));
        model_next();
        @(posedge Clk);
        #1;
        if (do_chk) begin
            chk("pc", 32'(PC), 32'(m_pc));
            chk("cycle_count", 32'(CycleCount), 32'(m_cnt));
            chk("running", 32'(Running), 32'(m_mode == M_RUN));
            chk("done", 32'(Done), 32'(m_mode == M_HALT));
        end
    endtask

    task automatic plain(input int n);
        BranchEn = 1'b0; BranchTaken = 1'b0; HaltInstr = 1'b0; Stall = 1'b0; Start = 1'b0;
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic restart();
        Start = 1'b1; step(1'b1);
        Start = 1'b0; step(1'b1);
    endtask

    initial begin
        // Reset state
        Reset = 1'b1; step(1'b1);
        chk("rst_pc", 32'(PC), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        Reset = 1'b0;

        // Start held two cycles, then 5 plain instructions and a halt
        Start = 1'b1; step(1'b1); step(1'b1);
        chk("load_running", 32'(Running), 32'd0);
        Start = 1'b0; step(1'b1);
        chk("run_pc0", 32'(PC), 32'd0);
        chk("run_running", 32'(Running), 32'd1);
        plain(5);
        chk("pc_at_5", 32'(PC), 32'd5);
        HaltInstr = 1'b1; BranchEn = 1'b1; BranchTaken = 1'b1; LutTarget = 10'd300;
        step(1'b1);
        HaltInstr = 1'b0; BranchEn = 1'b0; BranchTaken = 1'b0;
        chk("halt_done", 32'(Done), 32'd1);
        chk("halt_running", 32'(Running), 32'd0);
        chk("halt_pc", 32'(PC), 32'd5);
        chk("halt_count", 32'(CycleCount), 32'd6);
        plain(2);
        chk("halt_pc_hold", 32'(PC), 32'd5);

        // Start from HALT clears Done and the counter
        Start = 1'b1; step(1'b1);
        chk("reload_done", 32'(Done), 32'd0);
        chk("reload_count", 32'(CycleCount), 32'd0);
        Start = 1'b0; step(1'b1);

        // Taken branch through the LUT
        plain(10);
        BranchEn = 1'b1; BranchTaken = 1'b1; BranchAddr = 3'd2; LutTarget = 10'd418;
        #1 chk("lut_addr_same_cycle", 32'(LutAddr), 32'd2);
        step(1'b1);
        chk("branch_pc", 32'(PC), 32'd418);

        // Not-taken branch falls through
        restart();
        plain(10);
        BranchEn = 1'b1; BranchTaken = 1'b0; BranchAddr = 3'd5; LutTarget = 10'd418;
        step(1'b1);
        chk("not_taken_pc", 32'(PC), 32'd11);

        // Stall for three cycles at PC=20
        plain(9);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            chk("stall_pc", 32'(PC), 32'd20);
            chk("stall_count", 32'(CycleCount), 32'd20);
        end
        Stall = 1'b0; step(1'b1);
        chk("unstall_pc", 32'(PC), 32'd21);

        // Sentinel branch target halts without loading the PC
        BranchEn = 1'b1; BranchTaken = 1'b1; LutTarget = 10'd1023;
        step(1'b1);
        chk("sentinel_done", 32'(Done), 32'd1);
        chk("sentinel_pc", 32'(PC), 32'd21);

        // Reset in the middle of RUN at PC=37
        restart();
        plain(37);
        chk("pre_rst_pc", 32'(PC), 32'd37);
        chk("pre_rst_count", 32'(CycleCount), 32'd37);
        Reset = 1'b1; step(1'b1); Reset = 1'b0;
        chk("mid_rst_pc", 32'(PC), 32'd0);
        chk("mid_rst_count", 32'(CycleCount), 32'd0);
        chk("mid_rst_running", 32'(Running), 32'd0);
        plain(2);
        chk("idle_stays", 32'(Running), 32'd0);

        // PC wrap at 1023 and counter saturation
        restart();
        BranchEn = 1'b0; BranchTaken = 1'b0;
        for (int i = 0; i < 1023; i++) step(1'b0);
        chk("pc_1023", 32'(PC), 32'd1023);
        step(1'b1);
        chk("pc_wrap", 32'(PC), 32'd0);
        for (int i = 0; i < CNT_MAX - 1024 + 3; i++) step(1'b0);
        chk("count_sat", 32'(CycleCount), 32'(CNT_MAX));
        step(1'b1);
        chk("count_sat_hold", 32'(CycleCount), 32'(CNT_MAX));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            Reset       = ($urandom_range(0, 299) == 0);
            Start       = ($urandom_range(0, 24) == 0);
            Stall       = ($urandom_range(0, 5) == 0);
            HaltInstr   = ($urandom_range(0, 39) == 0);
            BranchEn    = ($urandom_range(0, 3) == 0);
            BranchTaken = ($urandom_range(0, 1) == 0);
            BranchAddr  = 3'($urandom);
            LutTarget   = ($urandom_range(0, 15) == 0) ? 10'd1023 : 10'($urandom_range(0, 1022));
            step(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
